// File: rtl/trace_pkg.sv
// Shared definitions for the wand-trace path: grid geometry, checker states and the trace type.
package trace_pkg;

    localparam int unsigned GRID_W  = 4;
    localparam int unsigned GRID_H  = 4;
    localparam int unsigned N_CELLS = GRID_W * GRID_H;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ROW_W   = 2;
    localparam int unsigned COL_W   = 2;
    localparam int unsigned PROG_W  = 5;

    typedef logic [N_CELLS-1:0] trace_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_t;

    function automatic logic [ROW_W-1:0] cell_row(input logic [IDX_W-1:0] idx);
        return ROW_W'(idx / IDX_W'(GRID_W));
    endfunction

    function automatic logic [COL_W-1:0] cell_col(input logic [IDX_W-1:0] idx);
        return COL_W'(idx % IDX_W'(GRID_W));
    endfunction

endpackage

// File: rtl/trace_adjacency.sv
// Orthogonal adjacency of two grid cells; rows never wrap into each other.
module trace_adjacency
    import trace_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       adj
);

    logic [ROW_W-1:0] row_a, row_b, row_d;
    logic [COL_W-1:0] col_a, col_b, col_d;

    assign row_a = cell_row(a);
    assign row_b = cell_row(b);
    assign col_a = cell_col(a);
    assign col_b = cell_col(b);

    assign row_d = (row_a > row_b) ? (row_a - row_b) : (row_b - row_a);
    assign col_d = (col_a > col_b) ? (col_a - col_b) : (col_b - col_a);

    assign adj = ((row_a == row_b) && (col_d == COL_W'(1)))
              || ((col_a == col_b) && (row_d == ROW_W'(1)));

endmodule

// File: rtl/trace_checker.sv
// Checks the player's cell-by-cell drawing against a latched 4x4 trace and
// reports progress, then pass, fail or idle timeout.
module trace_checker
    import trace_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned TMO_W          = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] trace_in,
    input  logic        cell_valid,
    input  logic [3:0]  cell_idx,
    input  logic        finish,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [4:0]  progress
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    trace_t           target;
    trace_t           visited;
    logic [3:0]       last;
    logic             has_last;
    logic [TMO_W-1:0] idle_cnt;

    logic   adj_c;
    logic   cell_bad_c;
    trace_t new_bit_c;
    trace_t visited_nx_c;

    trace_adjacency u_adj (
        .a   (cell_idx),
        .b   (last),
        .adj (adj_c)
    );

    assign new_bit_c    = trace_t'(1) << cell_idx;
    assign visited_nx_c = visited | new_bit_c;
    assign cell_bad_c   = !target[cell_idx] || (has_last && !adj_c);

    // Start wins over everything but reset; PASS/FAIL/IDLE just hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            target   <= '0;
            visited  <= '0;
            last     <= '0;
            has_last <= 1'b0;
            idle_cnt <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            progress <= '0;
        end else if (start) begin
            target   <= trace_in;
            visited  <= '0;
            last     <= '0;
            has_last <= 1'b0;
            idle_cnt <= '0;
            progress <= '0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            if (trace_in == '0) begin
                state <= PASS;
                busy  <= 1'b0;
                pass  <= 1'b1;
            end else begin
                state <= TRACK;
                busy  <= 1'b1;
                pass  <= 1'b0;
            end
        end else begin
            case (state)
                TRACK: begin
                    if (cell_valid) begin
                        idle_cnt <= '0;
                        if (cell_bad_c) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else begin
                            last     <= cell_idx;
                            has_last <= 1'b1;
                            visited  <= visited_nx_c;
                            if (!visited[cell_idx]) begin
                                progress <= progress + 5'd1;
                            end
                            if (visited_nx_c == target) begin
                                state <= PASS;
                                busy  <= 1'b0;
                                pass  <= 1'b1;
                            end else if (finish) begin
                                state <= FAIL;
                                busy  <= 1'b0;
                                fail  <= 1'b1;
                            end
                        end
                    end else if (finish) begin
                        state <= FAIL;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                    end else if (idle_cnt == TMO_LAST) begin
                        state   <= FAIL;
                        busy    <= 1'b0;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Consumer end of the wand-trace path: takes a 16-bit trace produced by the trace generator and checks the player's cell-by-cell drawing against it.
- Trace is a 4x4 grid. Bit index = row*4 + col; row 0 is bits 3:0.
- Reports progress while the player draws, then pass, fail or timeout to the game FSM.

Parameters:
- GRID_W, 4, grid columns
- GRID_H, 4, grid rows; N_CELLS = GRID_W*GRID_H = 16
- TIMEOUT_CYCLES, 50000000, max idle cycles between player cells before failure
- TMO_W, 26, width of the idle counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: latch trace_in and begin checking
- trace_in  in  16  target trace, sampled only when start=1
- cell_valid  in  1  one-cycle strobe: player touched cell_idx
- cell_idx  in  4  cell index 0..15
- finish  in  1  player declares the drawing complete
- busy  out  1  high in TRACK
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- timeout  out  1  high in FAIL when the cause was the idle timer
- progress  out  5  count of distinct correct cells visited, 0..16

Behaviour:
- Reset: state=IDLE; busy, pass, fail and timeout = 0; progress=0; target, visited and idle counter cleared. Reset overrides start.
- FSM states: IDLE, TRACK, PASS, FAIL. All outputs are registered.
- start, from any state:
  - target<=trace_in; visited<=0; progress<=0; idle counter<=0; has_last<=0.
  - If trace_in==0, go to PASS; otherwise go to TRACK.
  - start wins over cell_valid and finish in the same cycle; those inputs are ignored.
- TRACK, on cell_valid (evaluate in this order):
  1. target[cell_idx]==0 -> FAIL.
  2. has_last=1 and cell_idx is not orthogonally adjacent to last -> FAIL.
     - Adjacent means same row with |col diff|=1, or same col with |row diff|=1.
     - No row wrap: cells 3 and 4 are not adjacent.
  3. Otherwise: last<=cell_idx; has_last<=1.
     - If visited[cell_idx]==0: set the bit and increment progress.
     - Revisiting an already-visited cell is a legal backtrack; it only updates last.
  4. If visited|new_bit == target -> PASS, with progress updated in the same edge.
- Latency: pass or fail is visible the cycle after the deciding cell_valid edge.
- TRACK, on finish with visited != target and no cell_valid in that cycle -> FAIL.
  - If cell_valid and finish coincide, the cell is processed first; finish is then ignored if the cell completes the trace.
- Idle timer:
  - Counts every TRACK cycle; cleared on each cell_valid.
  - On reaching TIMEOUT_CYCLES-1 without cell_valid -> FAIL with timeout=1.
  - Counter saturates; it never wraps.
- PASS and FAIL hold all outputs until start or reset. cell_valid and finish are ignored there.
- IDLE ignores cell_valid and finish.
- timeout clears on start or reset.

Decomposition:
- Package trace_pkg holds:
  - GRID_W, GRID_H, N_CELLS
  - the state enum (IDLE, TRACK, PASS, FAIL)
  - the function cell_row / cell_col
  - the shared 16-bit trace typedef, also used by the generator
- One sub-module, trace_adjacency: combinational; inputs a,b [3:0]; output adj. Instanced once; reused later for the generator rework.

Test Plan:
- start with trace_in=16'h000F; cells 0,1,2,3 -> progress 1,2,3,4; pass=1 the cycle after cell 3; busy=0.
- trace_in=16'h000F; cells 0,2 -> fail=1 after cell 2 (non-adjacent); progress stays 1; timeout=0.
- trace_in=16'h0018 (cells 3,4); cells 3,4 -> fail (row-wrap not adjacent).
- trace_in=16'h1111; cells 0,4,0,4,8,12 -> backtrack accepted; progress reaches 4 only at cell 12; pass=1.
- TIMEOUT_CYCLES=8; trace_in=16'h0003; cell 0 then no input -> fail=1 and timeout=1 exactly 8 cycles after cell 0.
- Corner cases:
  - trace_in=0 -> pass the next cycle.
  - reset during TRACK at progress=2 -> all outputs 0, state IDLE.
  - start coincident with cell_valid -> cell ignored; progress=0.
